// File: rtl/cordic_pkg.sv
// Shared widths, bundles and helpers for the CORDIC pipe controller.
// Everything in the controller and its result FIFO is sized from here.
package cordic_pkg;

  localparam int DEF_W     = 16;
  localparam int DEF_IDX_W = 11;
  localparam int DEF_LAT   = 8;
  localparam int DEF_TAG_W = 4;
  localparam int DEF_DEPTH = 4;

  typedef struct packed {
    logic [DEF_W-1:0]     xm;
    logic [DEF_W-1:0]     ym;
    logic [DEF_TAG_W-1:0] tag;
  } res_t;

  typedef struct packed {
    logic [DEF_W-1:0]     xm;
    logic [DEF_W-1:0]     ym;
    logic [DEF_W-1:0]     xr;
    logic [DEF_W-1:0]     yr;
    logic [DEF_IDX_W-1:0] index;
    logic [DEF_TAG_W-1:0] tag;
  } op_t;

  function automatic int cred_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cordic_res_fifo.sv
// First-word fall-through result FIFO with modulo-DEPTH pointers.
// DEPTH need not be a power of two.
module cordic_res_fifo
  import cordic_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = cred_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          push,
  input  res_t          din,
  input  logic          pop,
  output res_t          dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  res_t          mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = inc(wr_q);
    if (do_pop)  rd_d = inc(rd_q);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (clr) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the head is only meaningful when !empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/cordic_pipe_ctrl.sv
// Issue, tracking-line and credit control around a fixed-latency CORDIC pipe.
// Credits bound pipe + FIFO occupancy, so the pipe never needs to stall.
module cordic_pipe_ctrl
  import cordic_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int IDX_W = DEF_IDX_W,
  parameter int LAT   = DEF_LAT,
  parameter int DEPTH = DEF_DEPTH,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 in_xm,
  input  logic [W-1:0]                 in_ym,
  input  logic [W-1:0]                 in_xr,
  input  logic [W-1:0]                 in_yr,
  input  logic [IDX_W-1:0]             in_index,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         pipe_issue,
  output logic [W-1:0]                 pipe_xm,
  output logic [W-1:0]                 pipe_ym,
  output logic [W-1:0]                 pipe_xr,
  output logic [W-1:0]                 pipe_yr,
  output logic [IDX_W-1:0]             pipe_index,
  input  logic [W-1:0]                 pipe_res_xm,
  input  logic [W-1:0]                 pipe_res_ym,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 out_xm,
  output logic [W-1:0]                 out_ym,
  output logic [TAG_W-1:0]             out_tag,
  output logic [$clog2(DEPTH+1)-1:0]   inflight
);

  localparam int CW = cred_w(DEPTH);

  op_t              op_q, op_d;
  logic             iss_q, iss_d;
  logic [LAT-1:0]   vld_q, vld_d;
  logic [TAG_W-1:0] tag_q [LAT];
  logic [TAG_W-1:0] tag_d [LAT];
  logic [CW-1:0]    cred_q, cred_d;

  logic             accept;
  logic             pop;
  logic             push;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             unused_fifo;
  res_t             wr_res;
  res_t             head;

  assign in_ready = reset && (cred_q != '0) && !clr;
  assign accept   = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop      = out_valid && out_ready && !clr;
  assign push     = vld_q[LAT-1] && !clr;

  assign wr_res.xm  = pipe_res_xm;
  assign wr_res.ym  = pipe_res_ym;
  assign wr_res.tag = tag_q[LAT-1];

  always_comb begin
    op_d  = op_q;
    iss_d = 1'b0;
    if (accept) begin
      op_d.xm    = in_xm;
      op_d.ym    = in_ym;
      op_d.xr    = in_xr;
      op_d.yr    = in_yr;
      op_d.index = in_index;
      op_d.tag   = in_tag;
      iss_d      = 1'b1;
    end
    vld_d[0] = iss_q;
    tag_d[0] = op_q.tag;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
    // Dropping valid bits is enough to discard stale pipe results.
    if (clr) begin
      vld_d = '0;
      iss_d = 1'b0;
    end
    cred_d = cred_q;
    unique case (1'b1)
      clr:            cred_d = CW'(DEPTH);
      accept && !pop: cred_d = cred_q - CW'(1);
      pop && !accept: cred_d = cred_q + CW'(1);
      default:        cred_d = cred_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q   <= '0;
      iss_q  <= 1'b0;
      vld_q  <= '0;
      cred_q <= CW'(DEPTH);
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      op_q   <= op_d;
      iss_q  <= iss_d;
      vld_q  <= vld_d;
      cred_q <= cred_d;
      for (int i = 0; i < LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  cordic_res_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .push  (push),
    .din   (wr_res),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign unused_fifo = ^{full, count};

  assign pipe_issue = iss_q;
  assign pipe_xm    = op_q.xm;
  assign pipe_ym    = op_q.ym;
  assign pipe_xr    = op_q.xr;
  assign pipe_yr    = op_q.yr;
  assign pipe_index = op_q.index;
  assign out_xm     = head.xm;
  assign out_ym     = head.ym;
  assign out_tag    = head.tag;
  assign inflight   = CW'(DEPTH) - cred_q;

endmodule

// File: tb/tb_cordic_pipe_ctrl.sv
// Randomised bench for cordic_pipe_ctrl against a queue-based reference.
// A model pipe returns operands + 1 after LAT edges.
module tb_cordic_pipe_ctrl;

  localparam int W     = 16;
  localparam int IDX_W = 11;
  localparam int LAT   = 8;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int IW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_xm = '0, in_ym = '0, in_xr = '0, in_yr = '0;
  logic [IDX_W-1:0] in_index = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             pipe_issue;
  logic [W-1:0]     pipe_xm, pipe_ym, pipe_xr, pipe_yr;
  logic [IDX_W-1:0] pipe_index;
  logic [W-1:0]     pipe_res_xm, pipe_res_ym;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_xm, out_ym;
  logic [TAG_W-1:0] out_tag;
  logic [IW-1:0]    inflight;

  cordic_pipe_ctrl #(
    .W(W), .IDX_W(IDX_W), .LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_xm(in_xm), .in_ym(in_ym), .in_xr(in_xr), .in_yr(in_yr),
    .in_index(in_index), .in_tag(in_tag),
    .pipe_issue(pipe_issue),
    .pipe_xm(pipe_xm), .pipe_ym(pipe_ym),
    .pipe_xr(pipe_xr), .pipe_yr(pipe_yr),
    .pipe_index(pipe_index),
    .pipe_res_xm(pipe_res_xm), .pipe_res_ym(pipe_res_ym),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_xm(out_xm), .out_ym(out_ym), .out_tag(out_tag),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  logic [W-1:0] px [LAT];
  logic [W-1:0] py [LAT];

  always @(posedge clk) begin
    px[0] <= pipe_xm;
    py[0] <= pipe_ym;
    for (int i = 1; i < LAT; i++) begin
      px[i] <= px[i-1];
      py[i] <= py[i-1];
    end
  end

  assign pipe_res_xm = px[LAT-1] + W'(1);
  assign pipe_res_ym = py[LAT-1] + W'(1);

  typedef struct {
    logic [W-1:0]     xm;
    logic [W-1:0]     ym;
    logic [TAG_W-1:0] tag;
    int               rdy;
  } exp_t;

  exp_t             q[$];
  int               cyc = 0;
  int               n_tests = 0;
  int               n_fail = 0;
  logic             iss_exp = 1'b0;
  logic [W-1:0]     l_xm = '0, l_ym = '0, l_xr = '0, l_yr = '0;
  logic [IDX_W-1:0] l_idx = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic head_ready();
    return (q.size() > 0) && (q[0].rdy <= cyc);
  endfunction

  task automatic check_all();
    logic ov;
    ov = head_ready();
    chk("in_ready", in_ready, (q.size() < DEPTH) && !clr);
    chk("inflight", inflight, q.size());
    chk("out_valid", out_valid, ov);
    if (ov) begin
      chk("out_xm", out_xm, q[0].xm);
      chk("out_ym", out_ym, q[0].ym);
      chk("out_tag", out_tag, q[0].tag);
    end
    chk("pipe_issue", pipe_issue, iss_exp);
    chk("pipe_xy", {pipe_xm, pipe_ym}, {l_xm, l_ym});
    chk("pipe_r", {pipe_xr, pipe_yr}, {l_xr, l_yr});
    chk("pipe_index", pipe_index, l_idx);
    chk("fifo_no_ovf", dut.u_fifo.push && dut.u_fifo.full, 0);
  endtask

  task automatic step(input logic v, input logic ordy, input logic c,
                      input logic [TAG_W-1:0] tg,
                      input logic [W-1:0] xm, input logic [W-1:0] ym,
                      output logic acc);
    logic             pp;
    logic [W-1:0]     xr, yr;
    logic [IDX_W-1:0] idx;
    exp_t             e;
    xr  = W'($urandom);
    yr  = W'($urandom);
    idx = IDX_W'($urandom);
    @(negedge clk);
    in_valid  = v;
    out_ready = ordy;
    clr       = c;
    in_xm     = xm;
    in_ym     = ym;
    in_xr     = xr;
    in_yr     = yr;
    in_index  = idx;
    in_tag    = tg;
    #1;
    check_all();
    acc = v && (q.size() < DEPTH) && !c;
    pp  = head_ready() && ordy && !c;
    @(posedge clk);
    cyc++;
    if (c) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        e.xm  = xm + W'(1);
        e.ym  = ym + W'(1);
        e.tag = tg;
        e.rdy = cyc + LAT + 1;
        q.push_back(e);
      end
    end
    iss_exp = acc;
    if (acc) begin
      l_xm  = xm;
      l_ym  = ym;
      l_xr  = xr;
      l_yr  = yr;
      l_idx = idx;
    end
  endtask

  task automatic rstep(input logic v, input logic ordy, input logic c);
    logic a;
    step(v, ordy, c, TAG_W'($urandom), W'($urandom), W'($urandom), a);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) rstep(1'b0, ordy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_issue", pipe_issue, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_pipe", {pipe_xm, pipe_ym, pipe_xr, pipe_yr}, 0);
    chk("rst_index", pipe_index, 0);
    q.delete();
    iss_exp = 1'b0;
    l_xm = '0; l_ym = '0; l_xr = '0; l_yr = '0; l_idx = '0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    cyc++;
  endtask

  logic         a;
  int           sent;
  logic [W-1:0] bx [6];
  logic [W-1:0] by [6];

  initial begin
    do_reset();

    // single op
    step(1'b1, 1'b0, 1'b0, 4'd3, 16'h0100, 16'h0200, a);
    idle(LAT + 1, 1'b0);
    #1;
    chk("single_valid", out_valid, 1);
    chk("single_xm", out_xm, 16'h0101);
    chk("single_ym", out_ym, 16'h0201);
    chk("single_tag", out_tag, 3);
    chk("single_inflight", inflight, 1);
    idle(3, 1'b1);

    // streaming
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, 1'b0, TAG_W'(i), W'($urandom), W'($urandom), a);
    idle(LAT + 4, 1'b1);

    // backpressure, then offer until all six are in
    for (int i = 0; i < 6; i++) begin
      bx[i] = W'($urandom);
      by[i] = W'($urandom);
    end
    sent = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0, TAG_W'(sent), bx[sent], by[sent], a);
      if (a) sent++;
    end
    chk("bp_accepted", sent, 4);
    idle(LAT + 2, 1'b0);
    #1;
    chk("bp_inflight", inflight, 4);
    chk("bp_in_ready", in_ready, 0);
    rstep(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 60 && sent < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, TAG_W'(sent), bx[sent], by[sent], a);
      if (a) sent++;
    end
    chk("bp_all_sent", sent, 6);
    idle(LAT + 6, 1'b1);

    // accept and pop together at one remaining credit
    for (int i = 0; i < DEPTH - 1; i++) rstep(1'b1, 1'b0, 1'b0);
    idle(LAT + 1, 1'b0);
    rstep(1'b1, 1'b1, 1'b0);
    #1;
    chk("simul_inflight", inflight, DEPTH - 1);
    idle(LAT + 6, 1'b1);

    // clr with work in both FIFO and pipe
    rstep(1'b1, 1'b0, 1'b0);
    rstep(1'b1, 1'b0, 1'b0);
    idle(LAT + 1, 1'b0);
    rstep(1'b1, 1'b0, 1'b0);
    rstep(1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    rstep(1'b0, 1'b1, 1'b1);
    #1;
    chk("clr_out_valid", out_valid, 0);
    chk("clr_inflight", inflight, 0);
    idle(LAT + 3, 1'b1);
    rstep(1'b1, 1'b1, 1'b0);
    idle(LAT + 3, 1'b1);

    // reset mid-flight
    rstep(1'b1, 1'b0, 1'b0);
    rstep(1'b1, 1'b0, 1'b0);
    idle(LAT, 1'b0);
    rstep(1'b1, 1'b0, 1'b0);
    do_reset();
    rstep(1'b1, 1'b1, 1'b0);
    idle(LAT + 3, 1'b1);

    // random traffic
    for (int i = 0; i < 500; i++)
      rstep(($urandom % 4) != 0, ($urandom % 3) != 0,
            ($urandom % 40) == 0);
    idle(LAT + 6, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
